ifu_inst_queue: RTL and testbench

IFU_INST_QUEUE -- requirements
Module: ifu_inst_queue

---
 rtl/ifu_inst_queue.sv | 135 +++++++++++++
 tb/tb_ifu_inst_queue.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ifu_inst_queue.sv
// Dual-issue instruction queue between fetch and decode: a circular buffer of {inst, addr, pred_branch}.
// Optional same-cycle empty-queue bypass is compiled in with IFU_INST_QUEUE_BYPASS_EN.
module ifu_inst_queue #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned INST_DATA_WIDTH = 32,
  parameter int unsigned INST_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       stall_i,
  input  logic [INST_DATA_WIDTH-1:0] inst1_i,
  input  logic [INST_ADDR_WIDTH-1:0] inst1_addr_i,
  input  logic                       inst1_pred_branch_i,
  input  logic                       inst1_valid_i,
  input  logic [INST_DATA_WIDTH-1:0] inst2_i,
  input  logic [INST_ADDR_WIDTH-1:0] inst2_addr_i,
  input  logic                       inst2_pred_branch_i,
  input  logic                       inst2_valid_i,
  output logic                       in_ready_o,
  output logic [INST_DATA_WIDTH-1:0] inst1_o,
  output logic [INST_ADDR_WIDTH-1:0] inst1_addr_o,
  output logic                       is_pred_branch1_o,
  output logic                       inst1_valid_o,
  output logic [INST_DATA_WIDTH-1:0] inst2_o,
  output logic [INST_ADDR_WIDTH-1:0] inst2_addr_o,
  output logic                       is_pred_branch2_o,
  output logic                       inst2_valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("ifu_inst_queue: DEPTH must be a power of two and at least 4");
  end

  logic [INST_DATA_WIDTH-1:0] r_inst_mem [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
  logic                       r_pred_mem [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_head_p1;
  logic [PTR_W-1:0] w_tail_p1;
  logic             w_in_ready;
  logic             w_q_v1;
  logic             w_q_v2;
  logic             w_bypass;
  logic [1:0]       w_push_n;
  logic [1:0]       w_pop_n;

  // Occupancy-derived status and push/pop amounts for this cycle.
  always_comb begin
    w_head_p1  = r_head + PTR_W'(1);
    w_tail_p1  = r_tail + PTR_W'(1);
    w_in_ready = (r_count <= CNT_W'(DEPTH - 2));
    w_q_v1     = (r_count != '0);
    w_q_v2     = (r_count >= CNT_W'(2));
`ifdef IFU_INST_QUEUE_BYPASS_EN
    w_bypass   = (r_count == '0) && !stall_i && !flush_i && !rst;
`else
    w_bypass   = 1'b0;
`endif
    w_push_n = 2'd0;
    if (w_in_ready && !flush_i && !w_bypass && inst1_valid_i) begin
      w_push_n = inst2_valid_i ? 2'd2 : 2'd1;
    end
    w_pop_n = 2'd0;
    if (!stall_i && !flush_i) begin
      w_pop_n = {1'b0, w_q_v1} + {1'b0, w_q_v2};
    end
  end

  // Pointer and occupancy state; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_n);
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_count <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
    end
  end

  // Storage is not reset; output masking hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && w_push_n != 2'd0) begin
      r_inst_mem[r_tail] <= inst1_i;
      r_addr_mem[r_tail] <= inst1_addr_i;
      r_pred_mem[r_tail] <= inst1_pred_branch_i;
      if (w_push_n == 2'd2) begin
        r_inst_mem[w_tail_p1] <= inst2_i;
        r_addr_mem[w_tail_p1] <= inst2_addr_i;
        r_pred_mem[w_tail_p1] <= inst2_pred_branch_i;
      end
    end
  end

  // Decode-facing slots; data is zeroed whenever the slot is not valid.
  always_comb begin
    in_ready_o    = w_in_ready;
    count_o       = r_count;
    inst1_valid_o = w_q_v1;
    inst2_valid_o = w_q_v2;
    inst1_o           = w_q_v1 ? r_inst_mem[r_head] : '0;
    inst1_addr_o      = w_q_v1 ? r_addr_mem[r_head] : '0;
    is_pred_branch1_o = w_q_v1 ? r_pred_mem[r_head] : 1'b0;
    inst2_o           = w_q_v2 ? r_inst_mem[w_head_p1] : '0;
    inst2_addr_o      = w_q_v2 ? r_addr_mem[w_head_p1] : '0;
    is_pred_branch2_o = w_q_v2 ? r_pred_mem[w_head_p1] : 1'b0;
`ifdef IFU_INST_QUEUE_BYPASS_EN
    if (w_bypass) begin
      inst1_valid_o     = inst1_valid_i;
      inst2_valid_o     = inst1_valid_i & inst2_valid_i;
      inst1_o           = inst1_valid_o ? inst1_i : '0;
      inst1_addr_o      = inst1_valid_o ? inst1_addr_i : '0;
      is_pred_branch1_o = inst1_valid_o & inst1_pred_branch_i;
      inst2_o           = inst2_valid_o ? inst2_i : '0;
      inst2_addr_o      = inst2_valid_o ? inst2_addr_i : '0;
      is_pred_branch2_o = inst2_valid_o & inst2_pred_branch_i;
    end
`endif
  end

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Directed self-checking bench for ifu_inst_queue (default build, DEPTH = 8, no bypass).
module tb_ifu_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, stall_i;
  logic [31:0] inst1_i, inst1_addr_i, inst2_i, inst2_addr_i;
  logic        inst1_pred_branch_i, inst1_valid_i, inst2_pred_branch_i, inst2_valid_i;
  logic        in_ready_o;
  logic [31:0] inst1_o, inst1_addr_o, inst2_o, inst2_addr_o;
  logic        is_pred_branch1_o, inst1_valid_o, is_pred_branch2_o, inst2_valid_o;
  logic [3:0]  count_o;

  int n_tests = 0;
  int n_fail  = 0;

  ifu_inst_queue #(.DEPTH(8), .INST_DATA_WIDTH(32), .INST_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
    .inst1_i(inst1_i), .inst1_addr_i(inst1_addr_i),
    .inst1_pred_branch_i(inst1_pred_branch_i), .inst1_valid_i(inst1_valid_i),
    .inst2_i(inst2_i), .inst2_addr_i(inst2_addr_i),
    .inst2_pred_branch_i(inst2_pred_branch_i), .inst2_valid_i(inst2_valid_i),
    .in_ready_o(in_ready_o),
    .inst1_o(inst1_o), .inst1_addr_o(inst1_addr_o),
    .is_pred_branch1_o(is_pred_branch1_o), .inst1_valid_o(inst1_valid_o),
    .inst2_o(inst2_o), .inst2_addr_o(inst2_addr_o),
    .is_pred_branch2_o(is_pred_branch2_o), .inst2_valid_o(inst2_valid_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [31:0] i1, input logic [31:0] a1, input logic p1,
                       input logic v2, input logic [31:0] i2, input logic [31:0] a2, input logic p2);
    inst1_valid_i = v1; inst1_i = i1; inst1_addr_i = a1; inst1_pred_branch_i = p1;
    inst2_valid_i = v2; inst2_i = i2; inst2_addr_i = a2; inst2_pred_branch_i = p2;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    idle();
    #1;
    tick();
    rst = 1'b0;
    check("rst_ready", 64'(in_ready_o), 64'd1);
    check("rst_v1",    64'(inst1_valid_o), 64'd0);
    check("rst_v2",    64'(inst2_valid_o), 64'd0);
    check("rst_inst1", 64'(inst1_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);

    // Basic pair push, one-cycle latency, then drained.
    drive(1'b1, 32'h0000_0013, 32'h8000_0000, 1'b0, 1'b1, 32'h0010_0093, 32'h8000_0004, 1'b1);
    tick();
    idle();
    check("b_v1",    64'(inst1_valid_o), 64'd1);
    check("b_v2",    64'(inst2_valid_o), 64'd1);
    check("b_inst1", 64'(inst1_o), 64'h0000_0013);
    check("b_addr1", 64'(inst1_addr_o), 64'h8000_0000);
    check("b_inst2", 64'(inst2_o), 64'h0010_0093);
    check("b_addr2", 64'(inst2_addr_o), 64'h8000_0004);
    check("b_pred1", 64'(is_pred_branch1_o), 64'd0);
    check("b_pred2", 64'(is_pred_branch2_o), 64'd1);
    check("b_count", 64'(count_o), 64'd2);
    tick();
    check("b_drain_count", 64'(count_o), 64'd0);
    check("b_drain_v1",    64'(inst1_valid_o), 64'd0);

    // Slot 2 valid without slot 1 is ignored.
    stall_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0001, 32'h9000_0000, 1'b0);
    tick();
    idle();
    check("s2only_count", 64'(count_o), 64'd0);
    check("s2only_v1",    64'(inst1_valid_o), 64'd0);

    // Fill to DEPTH under stall, drop the fifth pair, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(2*i), 32'h100 + 32'(8*i), 1'b0,
            1'b1, 32'h1001 + 32'(2*i), 32'h104 + 32'(8*i), 1'b0);
      tick();
    end
    check("full_count", 64'(count_o), 64'd8);
    check("full_ready", 64'(in_ready_o), 64'd0);
    check("full_hold_inst1", 64'(inst1_o), 64'h1000);
    drive(1'b1, 32'hDEAD, 32'hF00, 1'b0, 1'b1, 32'hBEEF, 32'hF04, 1'b0);
    tick();
    idle();
    check("drop5_count", 64'(count_o), 64'd8);
    stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_addr1", k), 64'(inst1_addr_o), 64'h100 + 64'(8*k));
      check($sformatf("drain%0d_addr2", k), 64'(inst2_addr_o), 64'h104 + 64'(8*k));
      check($sformatf("drain%0d_inst1", k), 64'(inst1_o), 64'h1000 + 64'(2*k));
      tick();
    end
    check("drain_count", 64'(count_o), 64'd0);

    // Count 7: pop 2 while the offered pair is refused.
    stall_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 32'h2000 + 32'(2*j), 32'h200 + 32'(8*j), 1'b0,
            1'b1, 32'h2001 + 32'(2*j), 32'h204 + 32'(8*j), 1'b0);
      tick();
    end
    drive(1'b1, 32'h2006, 32'h218, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("c7_count", 64'(count_o), 64'd7);
    check("c7_ready", 64'(in_ready_o), 64'd0);
    stall_i = 1'b0;
    drive(1'b1, 32'hAAAA, 32'hA00, 1'b0, 1'b1, 32'hBBBB, 32'hA04, 1'b0);
    tick();
    idle();
    check("c7_pop_count", 64'(count_o), 64'd5);
    check("c7_pop_addr1", 64'(inst1_addr_o), 64'h208);
    check("c7_ready_after", 64'(in_ready_o), 64'd1);

    // Flush beats stall and a same-cycle push.
    stall_i = 1'b1; flush_i = 1'b1;
    drive(1'b1, 32'hCCCC, 32'hC00, 1'b1, 1'b1, 32'hDDDD, 32'hC04, 1'b1);
    tick();
    flush_i = 1'b0;
    idle();
    check("fl_count", 64'(count_o), 64'd0);
    check("fl_v1",    64'(inst1_valid_o), 64'd0);
    check("fl_v2",    64'(inst2_valid_o), 64'd0);
    check("fl_inst1", 64'(inst1_o), 64'd0);
    check("fl_addr1", 64'(inst1_addr_o), 64'd0);
    check("fl_ready", 64'(in_ready_o), 64'd1);

    // Single entry: slot 2 masked; then push 2 while popping 1.
    drive(1'b1, 32'h3000, 32'h300, 1'b1, 1'b0, 32'h3001, 32'h304, 1'b0);
    tick();
    idle();
    check("one_count", 64'(count_o), 64'd1);
    check("one_v2",    64'(inst2_valid_o), 64'd0);
    check("one_inst2", 64'(inst2_o), 64'd0);
    check("one_pred1", 64'(is_pred_branch1_o), 64'd1);
    stall_i = 1'b0;
    drive(1'b1, 32'h3002, 32'h308, 1'b0, 1'b1, 32'h3003, 32'h30C, 1'b0);
    tick();
    idle();
    stall_i = 1'b1;
    check("pp_count", 64'(count_o), 64'd2);
    check("pp_addr1", 64'(inst1_addr_o), 64'h308);
    check("pp_addr2", 64'(inst2_addr_o), 64'h30C);

    // Reset mid-operation wins over a push.
    rst = 1'b1;
    drive(1'b1, 32'h4000, 32'h400, 1'b0, 1'b1, 32'h4001, 32'h404, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    check("mrst_count", 64'(count_o), 64'd0);
    check("mrst_v1",    64'(inst1_valid_o), 64'd0);
    check("mrst_addr1", 64'(inst1_addr_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
